// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch front end: keeps up to DEPTH fetches outstanding, buffers returned
// words in an in-order FIFO for decode, and flushes on redirect while discarding stale responses.
module inst_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          inst_req_valid,
  input  logic          inst_req_ready,
  output logic [31:0]   pc_req,
  input  logic [31:0]   instruction,
  input  logic          inst_valid,
  output logic          inst_ready,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          out_valid,
  output logic [31:0]   out_inst,
  output logic [31:0]   out_pc,
  input  logic          out_ready,
  output logic [CW-1:0] occupancy,
  output logic [31:0]   perf_issue_cnt,
  output logic [31:0]   perf_drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] CREDIT = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   issue_q, issue_d;
  logic [31:0]   drop_q, drop_d;
  logic [31:0]   fifo_inst_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic          req_fire, resp_fire, stale_hit, push, pop, drop;
  logic [CW:0]   credit_used;
  logic [31:0]   redirect_pc_aligned;

  assign credit_used         = {1'b0, count_q} + {1'b0, inflight_q};
  assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

  assign inst_req_valid = !rst && (credit_used < CREDIT);
  assign pc_req         = fetch_pc_q;
  assign inst_ready     = !rst;
  assign out_valid      = (count_q != '0);
  assign out_inst       = fifo_inst_q[rd_ptr_q];
  assign out_pc         = fifo_pc_q[rd_ptr_q];
  assign occupancy      = count_q;
  assign perf_issue_cnt = issue_q;
  assign perf_drop_cnt  = drop_q;

  assign req_fire  = inst_req_valid && inst_req_ready;
  assign resp_fire = inst_valid && inst_ready;
  assign stale_hit = (stale_q != '0);
  // A response landing in the redirect cycle belongs to the old stream, so it is dropped too.
  assign drop      = resp_fire && (stale_hit || redirect);
  assign push      = resp_fire && !stale_hit && !redirect;
  assign pop       = out_valid && out_ready && !redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    stale_d    = stale_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    issue_d    = issue_q;
    drop_d     = drop_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_fire);
    count_d    = count_q + CW'(push) - CW'(pop);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      issue_d    = issue_q + 32'd1;
    end
    if (drop) drop_d = drop_q + 32'd1;
    if (resp_fire && stale_hit) stale_d = stale_q - CW'(1);
    if (push) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      resp_pc_d = resp_pc_q + 32'd4;
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    // Everything still outstanding after this cycle was fetched for the old stream.
    if (redirect) begin
      fetch_pc_d = redirect_pc_aligned;
      resp_pc_d  = redirect_pc_aligned;
      stale_d    = inflight_d;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      stale_q    <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      issue_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      issue_q    <= issue_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_ptr_q] <= instruction;
      fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule
